rotated_window_collector: RTL and testbench
===========================================

Name: rotated_window_collector

Overview:
- Receive end of the rotated-window sampling path: accepts the serial stream of interpolated samples (one per `en` cycle, raster order) and reassembles it into a full winW×winH rotated window.
- Presents the assembled window as one parallel bus to downstream descriptor/gradient logic.
- Ping-pong double buffer, so the sampler can fill the next window while the previous one waits for `m_ready`.

Parameters:
- winW, 5, rotated window width in samples.
- winH, winW, rotated window height in samples.
- dataW, 8, sample width (interpolator outputW).
- N (localparam), winW*winH, samples per window.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous active-high reset.
- en  in  1  global clock-enable; when 0 all state holds.
- s_valid  in  1  input sample valid.
- s_first  in  1  marks sample 0 (top-left) of a window; qualified by s_valid.
- s_data  in  dataW  interpolated sample.
- s_ready  out  1  collector can accept a sample this cycle.
- m_valid  out  1  m_window holds a complete window.
- m_ready  in  1  downstream consumes window.
- m_window  out  winW*winH*dataW  sample k (k = y*winW + x) at bits [k*dataW +: dataW].
- sync_err  out  1  one-cycle pulse: window restarted by an unexpected s_first.

Behaviour:
- Storage: bank[0..1], each N×dataW. Per-bank full flag. Pointers wr_bank and rd_bank. Fill counter cnt in 0..N-1 (ceil(log2 N) bits).
- Handshakes:
  - Accept = en & s_valid & s_ready. Consume = en & m_valid & m_ready.
  - s_ready = en & ~full[wr_bank]. s_ready is combinational and does not depend on s_valid.
  - m_valid = full[rd_bank] (registered flag). m_window = bank[rd_bank], combinational mux.
- On accept:
  - Sample is written to bank[wr_bank] slot cnt (or slot 0, see s_first below).
  - If the slot written is N-1: full[wr_bank] <= 1, wr_bank toggles, cnt <= 0.
  - Otherwise cnt increments.
- s_first handling:
  - s_first with cnt==0: normal start.
  - s_first with cnt!=0: the partial window is discarded. The sample is written to slot 0, cnt <= 1, and sync_err pulses high for exactly the next cycle.
  - Missing s_first at cnt==0 is tolerated; the sample is taken as slot 0.
- On consume: full[rd_bank] <= 0, rd_bank toggles.
- Latency: m_valid rises on the cycle after the accept of sample N-1, when that bank is the read bank. If the other bank is still pending, the window becomes visible immediately after that bank is consumed.
- Simultaneous events:
  - Last-sample accept and consume in the same cycle operate on different banks; both take effect.
  - When both banks are full, s_ready stays 0 until a consume. s_ready rises the cycle after that consume (registered flag).
  - m_window is stable while m_valid=1 and m_ready=0.
- en=0: no accept, no consume, counters, flags and sync_err hold. sync_err is cleared only by a cycle with en=1.
- Reset, which overrides everything including en:
  - cnt=0, wr_bank=0, rd_bank=0, full=2'b00, sync_err=0.
  - Bank contents are not reset. m_window is don't-care while m_valid=0.
  - A reset mid-window drops the partial window and any full windows.
- Widths: no arithmetic on data; samples are stored verbatim.

Optional Feature:
- Macro: ROTWIN_COLLECT_ERRCNT_EN.
- Defined: adds output err_cnt [7:0].
  - Increments on each sync_err event.
  - Saturates at 8'hFF.
  - Cleared by rst.
  - Holds when en=0.
- Undefined: no err_cnt port; sync_err behaviour is unchanged.

Test Plan (winW=winH=5, dataW=8, N=25):
- Reset then 25 accepts of values 1..25, s_first on the first, m_ready=0 -> m_valid=1 on the cycle after accept 25; slot 0=8'd1, slot 24=8'd25; s_ready stays 1.
- Stream 75 samples back-to-back with m_ready=0 -> first 50 accepted; s_ready=0 from the cycle after accept 50. Raise m_ready for one cycle -> s_ready=1 the next cycle, and the second window (values 26..50) appears on m_window.
- Accept 10 samples, then s_first with data 8'hAA -> sync_err pulses once. After 24 more samples m_window slot 0=8'hAA and m_valid=1. With ERRCNT_EN, err_cnt=1.
- m_ready held 1 continuously, 3 windows streamed -> each window is visible for exactly one cycle, in order, and no sample is lost.
- en=0 for 5 cycles mid-window with s_valid=1 -> cnt unchanged and s_ready=0. Resume -> the window completes with correct slot ordering.
- Assert rst after 12 samples, then a fresh 25-sample window -> m_valid=0 during reset. The new window's slot 0 holds the first post-reset sample.

Source files
------------

// File: rtl/rotated_window_collector.sv
// rotated_window_collector
//
// Receive end of the rotated-window sampling path. Interpolated samples come
// in one per accepted cycle, in raster order, and are reassembled into a
// complete winW x winH window. The window is then presented as one wide
// parallel bus to the downstream descriptor/gradient logic. Two banks are
// used as a ping-pong buffer, so the sampler can fill the next window while
// the previous one waits for m_ready.
//
// Ports:
//   clk       clock; all logic on the rising edge
//   rst       synchronous active-high reset (overrides en)
//   en        global clock enable; when low, all state holds
//   s_valid   input sample valid
//   s_first   marks sample 0 (top-left) of a window; qualified by s_valid
//   s_data    interpolated sample, dataW bits
//   s_ready   collector can accept a sample this cycle
//   m_valid   m_window holds a complete window
//   m_ready   downstream consumes the window
//   m_window  sample k = y*winW + x at bits [k*dataW +: dataW]
//   sync_err  one-cycle pulse: a window was restarted by an unexpected s_first
//   err_cnt   (only with ROTWIN_COLLECT_ERRCNT_EN defined) saturating 8-bit
//             count of sync_err events
//
// Optional feature macro: ROTWIN_COLLECT_ERRCNT_EN

module rotated_window_collector #(
    parameter int winW  = 5,
    parameter int winH  = winW,
    parameter int dataW = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        en,
    input  logic                        s_valid,
    input  logic                        s_first,
    input  logic [dataW-1:0]            s_data,
    output logic                        s_ready,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [winW*winH*dataW-1:0]  m_window,
    output logic                        sync_err
`ifdef ROTWIN_COLLECT_ERRCNT_EN
    ,
    output logic [7:0]                  err_cnt
`endif
);

    localparam int N  = winW * winH;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_SLOT = CW'(N - 1);

    logic [N*dataW-1:0] bank [2];
    logic [1:0]         full;
    logic               wr_bank;
    logic               rd_bank;
    logic [CW-1:0]      cnt;

    logic               accept;
    logic               consume;
    logic               restart;
    logic [CW-1:0]      slot;

    // s_ready already contains en, so accept needs no separate en term.
    assign s_ready  = en & ~full[wr_bank];
    assign m_valid  = full[rd_bank];
    assign m_window = bank[rd_bank];

    assign accept   = s_valid & s_ready;
    assign consume  = en & m_valid & m_ready;

    // An s_first while a window is part-filled throws the partial window
    // away and restarts at slot 0.
    assign restart  = accept & s_first & (cnt != '0);
    assign slot     = s_first ? '0 : cnt;

    // Sample storage carries no reset; contents are only meaningful once
    // the matching full flag is set.
    always_ff @(posedge clk) begin
        if (accept) begin
            bank[wr_bank][slot*dataW +: dataW] <= s_data;
        end
    end

    // Accept and consume always address different banks (accept needs the
    // write bank empty, consume needs the read bank full), so both full-flag
    // updates can take effect in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            full     <= 2'b00;
            sync_err <= 1'b0;
        end else if (en) begin
            sync_err <= restart;
            if (accept) begin
                if (slot == LAST_SLOT) begin
                    full[wr_bank] <= 1'b1;
                    wr_bank       <= ~wr_bank;
                    cnt           <= '0;
                end else begin
                    cnt <= slot + 1'b1;
                end
            end
            if (consume) begin
                full[rd_bank] <= 1'b0;
                rd_bank       <= ~rd_bank;
            end
        end
    end

`ifdef ROTWIN_COLLECT_ERRCNT_EN
    // Counts restarts in the same cycle that raises sync_err; sticks at 255.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt <= 8'h00;
        end else if (en && restart && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'h01;
        end
    end
`endif

endmodule

// File: tb/tb_rotated_window_collector.sv
// tb_rotated_window_collector
//
// Scoreboard bench for rotated_window_collector (winW = winH = 5, dataW = 8).
// A reference model tracks the stream as a queue of partial samples plus a
// count of complete windows waiting downstream; every completed window is
// pushed into the expected-window queue. A monitor running on the falling
// edge compares the handshake flags every cycle and pops/compares a window
// whenever the DUT hands one over.

module tb_rotated_window_collector;

    localparam int W = 5;
    localparam int H = 5;
    localparam int D = 8;
    localparam int N = W * H;

    logic             clk;
    logic             rst;
    logic             en;
    logic             s_valid;
    logic             s_first;
    logic [D-1:0]     s_data;
    logic             s_ready;
    logic             m_valid;
    logic             m_ready;
    logic [N*D-1:0]   m_window;
    logic             sync_err;
`ifdef ROTWIN_COLLECT_ERRCNT_EN
    logic [7:0]       err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    bit started = 0;
    int popped = 0;

    // Reference model state
    logic [D-1:0]     part[$];
    logic [N*D-1:0]   expq[$];
    int               full_cnt = 0;
    bit               exp_sync = 0;
    int               exp_err = 0;

    rotated_window_collector #(
        .winW  (W),
        .winH  (H),
        .dataW (D)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .s_valid  (s_valid),
        .s_first  (s_first),
        .s_data   (s_data),
        .s_ready  (s_ready),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_window (m_window),
        .sync_err (sync_err)
`ifdef ROTWIN_COLLECT_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [N*D-1:0] act,
                               input logic [N*D-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drives one cycle of inputs shortly after the rising edge.
    task automatic applyStimulus(input bit r, input bit e, input bit v,
                                 input bit f, input logic [D-1:0] d,
                                 input bit mr);
        @(posedge clk);
        #2;
        rst     = r;
        en      = e;
        s_valid = v;
        s_first = f;
        s_data  = d;
        m_ready = mr;
    endtask

    task automatic doReset();
        applyStimulus(1, 1, 0, 0, 8'h00, 0);
        applyStimulus(1, 1, 0, 0, 8'h00, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        started = 1;
    endtask

    task automatic drain();
        int guard = 0;
        while ((full_cnt != 0) && (guard < 200)) begin
            applyStimulus(0, 1, 0, 0, 8'h00, 1);
            guard++;
        end
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        checkOutput("drain_empty", 32'(expq.size()), 0);
    endtask

    // Reference model: a window is the last N samples since the most recent
    // restart; at most two complete windows may be waiting downstream.
    always @(posedge clk) begin : model
        bit acc;
        bit con;
        bit sy;
        logic [N*D-1:0] win;
        if (rst) begin
            part.delete();
            expq.delete();
            full_cnt = 0;
            exp_sync = 0;
            exp_err  = 0;
        end else if (en) begin
            acc = s_valid && (full_cnt < 2);
            con = m_ready && (full_cnt > 0);
            sy  = 0;
            if (acc) begin
                if (s_first && (part.size() != 0)) begin
                    sy = 1;
                    if (exp_err < 255) exp_err++;
                end
                if (s_first) part.delete();
                part.push_back(s_data);
                if (part.size() == N) begin
                    win = '0;
                    for (int k = 0; k < N; k++) win[k*D +: D] = part[k];
                    expq.push_back(win);
                    full_cnt++;
                    part.delete();
                end
            end
            if (con) full_cnt--;
            exp_sync = sy;
        end
    end

    // Monitor: flags every cycle, window contents whenever m_valid is high.
    always @(negedge clk) begin
        if (started) begin
            checkOutput("m_valid", m_valid, full_cnt > 0);
            checkOutput("s_ready", s_ready, en && (full_cnt < 2));
            checkOutput("sync_err", sync_err, exp_sync);
`ifdef ROTWIN_COLLECT_ERRCNT_EN
            checkOutput("err_cnt", err_cnt, exp_err);
`endif
            if (m_valid === 1'b1) begin
                if (expq.size() == 0) begin
                    checkOutput("window_unexpected", 1, 0);
                end else begin
                    checkOutput("m_window", m_window, expq[0]);
                    if (m_ready && en && !rst) begin
                        void'(expq.pop_front());
                        popped++;
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: simulation did not end, errors so far %0d", errors);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int p0;
        rst = 1; en = 0; s_valid = 0; s_first = 0; s_data = '0; m_ready = 0;

        // One window of 1..25 held with m_ready low.
        doReset();
        for (int i = 1; i <= 25; i++) applyStimulus(0, 1, 1, i == 1, 8'(i), 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        @(negedge clk);
        checkOutput("t1_valid", m_valid, 1);
        checkOutput("t1_slot0", m_window[7:0], 8'd1);
        checkOutput("t1_slot24", m_window[24*8 +: 8], 8'd25);
        checkOutput("t1_ready", s_ready, 1);
        drain();

        // Back-to-back stream fills both banks, then one consume.
        doReset();
        for (int i = 1; i <= 75; i++) applyStimulus(0, 1, 1, i == 1, 8'(i), 0);
        @(negedge clk);
        checkOutput("t2_ready_low", s_ready, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 1);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        @(negedge clk);
        checkOutput("t2_ready_back", s_ready, 1);
        checkOutput("t2_slot0", m_window[7:0], 8'd26);
        checkOutput("t2_slot24", m_window[24*8 +: 8], 8'd50);
        drain();

        // Unexpected s_first restarts the window.
        doReset();
        for (int i = 1; i <= 10; i++) applyStimulus(0, 1, 1, i == 1, 8'(i), 0);
        applyStimulus(0, 1, 1, 1, 8'hAA, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        @(negedge clk);
        checkOutput("t3_sync_pulse", sync_err, 1);
        for (int i = 1; i <= 24; i++) applyStimulus(0, 1, 1, 0, 8'(100 + i), 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        @(negedge clk);
        checkOutput("t3_valid", m_valid, 1);
        checkOutput("t3_slot0", m_window[7:0], 8'hAA);
        checkOutput("t3_sync_clear", sync_err, 0);
`ifdef ROTWIN_COLLECT_ERRCNT_EN
        checkOutput("t3_err_cnt", err_cnt, 8'd1);
`endif
        drain();

        // m_ready held high: three windows pass through in order.
        doReset();
        p0 = popped;
        for (int i = 0; i < 75; i++) applyStimulus(0, 1, 1, (i % 25) == 0, 8'(i * 3), 1);
        for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 8'h00, 1);
        checkOutput("t4_windows", 32'(popped - p0), 3);
        drain();

        // en low mid-window with s_valid high.
        doReset();
        for (int i = 1; i <= 12; i++) applyStimulus(0, 1, 1, i == 1, 8'(i + 60), 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 0, 1, 0, 8'hEE, 0);
        @(negedge clk);
        checkOutput("t5_ready_en0", s_ready, 0);
        for (int i = 13; i <= 25; i++) applyStimulus(0, 1, 1, 0, 8'(i + 60), 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        @(negedge clk);
        checkOutput("t5_slot12", m_window[12*8 +: 8], 8'd73);
        drain();

        // Reset mid-window, then a fresh window.
        doReset();
        for (int i = 1; i <= 12; i++) applyStimulus(0, 1, 1, i == 1, 8'(i), 0);
        applyStimulus(1, 1, 1, 0, 8'h55, 0);
        @(negedge clk);
        checkOutput("t6_valid_in_rst", m_valid, 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        for (int i = 0; i < 25; i++) applyStimulus(0, 1, 1, 0, 8'(200 + i), 0);
        applyStimulus(0, 1, 0, 0, 8'h00, 0);
        @(negedge clk);
        checkOutput("t6_slot0", m_window[7:0], 8'd200);
        drain();

        // Randomised traffic, including stray s_first, en drops and resets.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            applyStimulus($urandom_range(0, 399) == 0,
                          $urandom_range(0, 9) != 0,
                          $urandom_range(0, 9) < 7,
                          $urandom_range(0, 14) == 0,
                          8'($urandom),
                          $urandom_range(0, 1) == 1);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
